// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath strobes, counts retired instructions and flags HALT/illegal opcodes.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             Mem2Reg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             PCSrc,
  output logic [4:0]       ALUOp,
  output logic             push,
  output logic             pop,
  output logic             pc_write,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t     state, state_nx;
  logic [5:0] op_q;

  logic is_r, is_i, is_lw, is_sw, is_beq, is_bne, is_call, is_ret, is_halt, is_def;
  assign is_r    = (op_q[5:4] == 2'b00);
  assign is_i    = (op_q[5:4] == 2'b01);
  assign is_lw   = (op_q == 6'h20);
  assign is_sw   = (op_q == 6'h21);
  assign is_beq  = (op_q == 6'h22);
  assign is_bne  = (op_q == 6'h23);
  assign is_call = (op_q == 6'h24);
  assign is_ret  = (op_q == 6'h25);
  assign is_halt = (op_q == 6'h3F);
  assign is_def  = is_r | is_i | is_lw | is_sw | is_beq | is_bne | is_call | is_ret | is_halt;

  // ALU controls that must stay stable from EXEC until the instruction retires
  logic [4:0] alu_op_d;
  logic       alu_src_d;
  assign alu_op_d  = (is_r | is_i) ? {1'b0, op_q[3:0]} : ((is_beq | is_bne) ? 5'd1 : 5'd0);
  assign alu_src_d = is_i | is_lw | is_sw;

  logic pc_wr_c, push_c, pop_c;

  always_comb begin
    state_nx = state;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    Mem2Reg  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    PCSrc    = 1'b0;
    ALUOp    = 5'd0;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    pc_wr_c  = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        illegal  = ~is_def;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        ALUOp  = alu_op_d;
        ALUSrc = alu_src_d;
        RegDst = is_r;
        if (is_r | is_i)          state_nx = S_WB;
        else if (is_lw | is_sw)   state_nx = S_MEM;
        else if (is_halt)         state_nx = S_HALT;
        else begin
          // branch / call / ret / nop all retire here
          PCSrc    = (is_beq & zero) | (is_bne & ~zero) | is_call;
          push_c   = is_call;
          pop_c    = is_ret;
          pc_wr_c  = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_MEM: begin
        ALUOp    = alu_op_d;
        ALUSrc   = alu_src_d;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready) begin
          if (is_lw) state_nx = S_WB;
          else begin
            pc_wr_c  = 1'b1;
            state_nx = S_FETCH;
          end
        end
      end
      S_WB: begin
        ALUOp    = alu_op_d;
        ALUSrc   = alu_src_d;
        RegDst   = is_r;
        Mem2Reg  = is_lw;
        RegWrite = 1'b1;
        pc_wr_c  = 1'b1;
        state_nx = S_FETCH;
      end
      default: state_nx = S_HALT;
    endcase
  end

  // a reset landing on the final cycle aborts the instruction: no PC/stack update
  assign pc_write = pc_wr_c & ~reset;
  assign push     = push_c & ~reset;
  assign pop      = pop_c & ~reset;
  assign halted   = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= 6'd0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH) op_q <= op;
      if (pc_write) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, randomized instruction stream against a
// per-instruction cycle-list model, and hand sequences for HALT and reset abort.
module tb_multicycle_ctrl;

  typedef logic [15:0] obs_t;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  op;
  logic        RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc;
  logic [4:0]  ALUOp;
  logic        push, pop, pc_write, halted, illegal;
  logic [31:0] retired;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .push(push), .pop(pop), .pc_write(pc_write), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  obs_t dut_obs;
  assign dut_obs = {RegDst, ALUSrc, Mem2Reg, MemRead, MemWrite, RegWrite, PCSrc,
                    ALUOp, push, pop, pc_write, illegal};

  // flags = {RegDst,ALUSrc,Mem2Reg,MemRead,MemWrite,RegWrite,PCSrc}; tail = {push,pop,pc_write,illegal}
  function automatic obs_t mk(input logic [6:0] flags, input logic [4:0] alu, input logic [3:0] tail);
    return {flags, alu, tail};
  endfunction

  int   n_chk = 0, n_fail = 0, exp_ret = 0;
  obs_t exp_q[$];
  obs_t got_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one instruction, built from the opcode class rules.
  task automatic build(input logic [5:0] o, input logic z, input int w);
    logic [4:0] alu;
    logic       src, rd, legal, take;
    exp_q.delete();
    alu   = (o < 6'h20) ? {1'b0, o[3:0]} : ((o == 6'h22 || o == 6'h23) ? 5'd1 : 5'd0);
    src   = (o >= 6'h10 && o <= 6'h21);
    rd    = (o < 6'h10);
    legal = (o <= 6'h25) || (o == 6'h3F);
    exp_q.push_back('0);
    exp_q.push_back(mk(7'b0, 5'd0, {3'b000, ~legal}));
    if (o < 6'h20) begin
      exp_q.push_back(mk({rd, src, 5'b00000}, alu, 4'b0000));
      exp_q.push_back(mk({rd, src, 5'b00010}, alu, 4'b0010));
    end else if (o == 6'h20 || o == 6'h21) begin
      exp_q.push_back(mk(7'b0100000, 5'd0, 4'b0000));
      for (int k = 0; k <= w; k++)
        exp_q.push_back(o == 6'h20 ? mk(7'b0101000, 5'd0, 4'b0000)
                                   : mk(7'b0100100, 5'd0, {2'b00, k == w, 1'b0}));
      if (o == 6'h20) exp_q.push_back(mk(7'b0110010, 5'd0, 4'b0010));
    end else if (o == 6'h3F) begin
      exp_q.push_back('0);
    end else begin
      take = (o == 6'h22 && z) || (o == 6'h23 && !z) || (o == 6'h24);
      exp_q.push_back(mk({6'b0, take}, alu, {o == 6'h24, o == 6'h25, 2'b10}));
    end
  endtask

  // Runs one instruction starting in FETCH (called at posedge+1), checking every cycle.
  task automatic run_instr(input logic [5:0] o, input logic z, input int w, output int pcw);
    logic is_mem;
    is_mem = (o == 6'h20 || o == 6'h21);
    build(o, z, w);
    got_q.delete();
    pcw = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      op   = (i == 0) ? o : 6'($urandom);
      zero = (i == 2) ? z : 1'($urandom);
      if (is_mem && i >= 3 && i <= 3 + w) mem_ready = (i == 3 + w);
      else                                mem_ready = 1'($urandom);
      @(negedge clk);
      got_q.push_back(dut_obs);
      if (pc_write && pcw < 0) pcw = i;
      chk($sformatf("cycle op=%h i=%0d", o, i), {15'b0, halted, dut_obs}, {15'b0, 1'b0, exp_q[i]});
      @(posedge clk); #1;
    end
    if (o != 6'h3F) begin
      exp_ret++;
      chk("retired", retired, 32'(exp_ret));
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         w;
    int         cyc;
    logic       ill;
    obs_t       ex;
    obs_t       fin;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pcw;
    tbl[0]  = '{6'h03, 1'b0, 0, 4, 1'b0, mk(7'b1000000, 5'h03, 4'b0000), mk(7'b1000010, 5'h03, 4'b0010)};
    tbl[1]  = '{6'h1A, 1'b0, 0, 4, 1'b0, mk(7'b0100000, 5'h0A, 4'b0000), mk(7'b0100010, 5'h0A, 4'b0010)};
    tbl[2]  = '{6'h20, 1'b0, 2, 7, 1'b0, mk(7'b0100000, 5'h00, 4'b0000), mk(7'b0110010, 5'h00, 4'b0010)};
    tbl[3]  = '{6'h21, 1'b0, 1, 5, 1'b0, mk(7'b0100000, 5'h00, 4'b0000), mk(7'b0100100, 5'h00, 4'b0010)};
    tbl[4]  = '{6'h21, 1'b1, 0, 4, 1'b0, mk(7'b0100000, 5'h00, 4'b0000), mk(7'b0100100, 5'h00, 4'b0010)};
    tbl[5]  = '{6'h22, 1'b1, 0, 3, 1'b0, mk(7'b0000001, 5'h01, 4'b0010), mk(7'b0000001, 5'h01, 4'b0010)};
    tbl[6]  = '{6'h22, 1'b0, 0, 3, 1'b0, mk(7'b0000000, 5'h01, 4'b0010), mk(7'b0000000, 5'h01, 4'b0010)};
    tbl[7]  = '{6'h23, 1'b0, 0, 3, 1'b0, mk(7'b0000001, 5'h01, 4'b0010), mk(7'b0000001, 5'h01, 4'b0010)};
    tbl[8]  = '{6'h23, 1'b1, 0, 3, 1'b0, mk(7'b0000000, 5'h01, 4'b0010), mk(7'b0000000, 5'h01, 4'b0010)};
    tbl[9]  = '{6'h24, 1'b0, 0, 3, 1'b0, mk(7'b0000001, 5'h00, 4'b1010), mk(7'b0000001, 5'h00, 4'b1010)};
    tbl[10] = '{6'h25, 1'b1, 0, 3, 1'b0, mk(7'b0000000, 5'h00, 4'b0110), mk(7'b0000000, 5'h00, 4'b0110)};
    tbl[11] = '{6'h30, 1'b0, 0, 3, 1'b1, mk(7'b0000000, 5'h00, 4'b0010), mk(7'b0000000, 5'h00, 4'b0010)};
    tbl[12] = '{6'h0F, 1'b1, 0, 4, 1'b0, mk(7'b1000000, 5'h0F, 4'b0000), mk(7'b1000010, 5'h0F, 4'b0010)};

    reset = 1'b1; op = 6'h3F; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset retired", retired, 32'd0);
    chk("reset halted", {31'b0, halted}, 32'd0);
    chk("reset strobes", {16'b0, dut_obs}, 32'd0);
    reset = 1'b0;

    foreach (tbl[n]) begin
      run_instr(tbl[n].op, tbl[n].z, tbl[n].w, pcw);
      chk($sformatf("tbl%0d cycles", n), 32'(pcw + 1), 32'(tbl[n].cyc));
      chk($sformatf("tbl%0d decode", n), {16'b0, got_q[1]}, {16'b0, mk(7'b0, 5'd0, {3'b000, tbl[n].ill})});
      chk($sformatf("tbl%0d exec", n), {16'b0, got_q[2]}, {16'b0, tbl[n].ex});
      chk($sformatf("tbl%0d final", n), {16'b0, (pcw < 0) ? 16'h0 : got_q[pcw]}, {16'b0, tbl[n].fin});
    end

    for (int n = 0; n < 60; n++) begin
      logic [5:0] o;
      case ($urandom_range(0, 3))
        0:       o = 6'($urandom_range(0, 62));
        1:       o = 6'($urandom_range(6'h20, 6'h21));
        2:       o = 6'($urandom_range(6'h22, 6'h25));
        default: o = 6'($urandom_range(0, 6'h1F));
      endcase
      run_instr(o, 1'($urandom), int'($urandom_range(0, 3)), pcw);
    end

    // HALT: no retire, absorbing with all strobes low, only reset exits
    run_instr(6'h3F, 1'b0, 0, pcw);
    chk("halt pc_write", 32'(pcw), 32'hFFFF_FFFF);
    for (int c = 0; c < 20; c++) begin
      op = 6'($urandom); zero = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
      chk($sformatf("halt cycle %0d", c), {15'b0, halted, dut_obs}, {15'b0, 1'b1, 16'h0});
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ret = 0;
    chk("post-halt reset halted", {31'b0, halted}, 32'd0);
    chk("post-halt reset retired", retired, 32'd0);

    // reset during an LW memory wait aborts it
    op = 6'h20; mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; op = 6'($urandom); end
    @(negedge clk);
    chk("abort MemRead before reset", {31'b0, MemRead}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort pc_write", {31'b0, pc_write}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort MemRead after reset", {31'b0, MemRead}, 32'd0);
    chk("abort retired", retired, 32'd0);
    run_instr(6'h30, 1'b0, 0, pcw);
    chk("after abort nop cycles", 32'(pcw + 1), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
